// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder.
//   MEM_BANDWIDTH : bytes per array word
//   MEM_ADDR_SIZE : width of word addresses; one bit wider than needed for
//                   the default 4096-word array so out-of-range addresses
//                   can be presented
//   MEM_ERR_BIT   : bit positions inside err_status
package mem_responder_pkg;

  localparam int MEM_BANDWIDTH = 4;
  localparam int MEM_ADDR_SIZE = 13;

  typedef enum logic [1:0] {
    ADDR_OOB     = 2'd0,
    RW_COLLISION = 2'd1,
    INIT_DROP    = 2'd2
  } MEM_ERR_BIT;

endpackage

// File: rtl/mem_responder_delay.sv
// mem_delay_line: fixed-length shift register that carries {valid, data}.
//   clk, rst_n          : clock, synchronous active-low reset (clears every stage)
//   in_valid, in_data   : value entering stage 0 on each rising edge
//   out_valid, out_data : last stage, DEPTH edges after entry
module mem_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH:0] stage_q [DEPTH];
  logic [WIDTH:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = {in_valid, in_data};
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign {out_valid, out_data} = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Single-port word memory model answering reads after a fixed latency.
//   clk, rst_n                          : clock, synchronous active-low reset
//   mem_addr, mem_read_valid,
//   mem_write_valid, mem_write_data     : request port (write wins a collision)
//   init_valid, init_addr, init_data    : preload port, only used on idle cycles
//   mem_data, mem_valid                 : read response, READ_LATENCY (1..8) cycles
//                                         after acceptance; data is 0 when not valid
//   read_count, write_count             : saturating accepted-access counters
//   err_status                          : sticky {init_drop, rw_collision, addr_oob}
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MEM_ADDR_SIZE-1:0]   mem_addr,
  input  logic                       mem_read_valid,
  input  logic                       mem_write_valid,
  input  logic [MEM_BANDWIDTH*8-1:0] mem_write_data,
  input  logic                       init_valid,
  input  logic [MEM_ADDR_SIZE-1:0]   init_addr,
  input  logic [MEM_BANDWIDTH*8-1:0] init_data,
  output logic [MEM_BANDWIDTH*8-1:0] mem_data,
  output logic                       mem_valid,
  output logic [31:0]                read_count,
  output logic [31:0]                write_count,
  output logic [2:0]                 err_status
);

  localparam int          DW      = MEM_BANDWIDTH * 8;
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [DW-1:0] mem_array_q [DEPTH];

  logic [31:0]   read_count_q, read_count_d;
  logic [31:0]   write_count_q, write_count_d;
  logic [2:0]    err_status_q, err_status_d;

  logic          addr_in_range, init_in_range, any_req;
  logic          rd_accept, init_ok;
  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [DW-1:0] arr_wdata;
  logic [DW-1:0] rd_data;

  always_comb begin
    addr_in_range = 32'(mem_addr) < DEPTH_U;
    init_in_range = 32'(init_addr) < DEPTH_U;
    any_req       = mem_read_valid || mem_write_valid;
    rd_accept     = rst_n && mem_read_valid && !mem_write_valid;
    init_ok       = init_valid && !any_req && init_in_range;

    // Host writes and preloads share the one write port; they never coincide
    // because a preload alongside any request is dropped.
    arr_we    = rst_n && ((mem_write_valid && addr_in_range) || init_ok);
    arr_waddr = mem_write_valid ? mem_addr[AW-1:0] : init_addr[AW-1:0];
    arr_wdata = mem_write_valid ? mem_write_data : init_data;

    // Data is captured at acceptance, so later writes cannot disturb an
    // in-flight response. Zero when not reading keeps mem_data clean.
    rd_data = (rd_accept && addr_in_range) ? mem_array_q[mem_addr[AW-1:0]] : '0;

    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    if (rd_accept && (read_count_q != 32'hFFFF_FFFF)) begin
      read_count_d = read_count_q + 32'd1;
    end
    if (mem_write_valid && (write_count_q != 32'hFFFF_FFFF)) begin
      write_count_d = write_count_q + 32'd1;
    end

    err_status_d = err_status_q;
    if (any_req && !addr_in_range) begin
      err_status_d[ADDR_OOB] = 1'b1;
    end
    if (mem_read_valid && mem_write_valid) begin
      err_status_d[RW_COLLISION] = 1'b1;
    end
    if (init_valid) begin
      if (any_req) begin
        err_status_d[INIT_DROP] = 1'b1;
      end else if (!init_in_range) begin
        err_status_d[ADDR_OOB] = 1'b1;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem_array_q[arr_waddr] <= arr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_count_q  <= '0;
      write_count_q <= '0;
      err_status_q  <= '0;
    end else begin
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
      err_status_q  <= err_status_d;
    end
  end

  mem_delay_line #(
    .DEPTH (READ_LATENCY),
    .WIDTH (DW)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_accept),
    .in_data   (rd_data),
    .out_valid (mem_valid),
    .out_data  (mem_data)
  );

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
  assign err_status  = err_status_q;

endmodule
